// File: rtl/layer_code_if.sv
// Byte-stream handshake between the byte source and the NeoPixel line encoder.
// One byte plus its end-of-frame flag moves on each clock edge where valid and ready are both high.
interface layer_code_if;
    logic       data_vld_in;
    logic [7:0] data_in;
    logic       data_last_in;
    logic       data_rdy_out;

    modport master (output data_vld_in, data_in, data_last_in, input data_rdy_out);
    modport slave  (input data_vld_in, data_in, data_last_in, output data_rdy_out);
endinterface

// File: rtl/layer_code.sv
// NeoPixel (WS2812-class) line encoder: serialises bytes MSB first using the layer_conf
// timing counts, then holds the line low for a reset/latch code after each frame's last byte.
module layer_code #(
    parameter int RST_CNT = 16000,
    parameter int RST_W   = 16
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [7:0]  t0h_cnt_in,
    input  logic [7:0]  t0s_cnt_in,
    input  logic [7:0]  t1h_cnt_in,
    input  logic [7:0]  t1s_cnt_in,
    layer_code_if.slave data_if,
    output logic        bit_code_out,
    output logic        busy_out,
    output logic        done_out
);
    typedef enum logic [1:0] {IDLE, SEND, RST} state_t;

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CNT - 1);

    state_t           state, state_nxt;
    logic             buf_full;
    logic [7:0]       buf_data;
    logic             buf_last;
    logic [7:0]       shift_q;
    logic             cur_last;
    logic [7:0]       h_q, s_q;
    logic [7:0]       cnt, cnt_nxt, cnt_inc;
    logic [2:0]       bit_idx, bit_nxt;
    logic [RST_W-1:0] rst_cnt, rst_cnt_nxt;
    logic             line_nxt, done_nxt, load, advance, sel_bit, accept;

    function automatic logic [RST_W-1:0] rst_inc(input logic [RST_W-1:0] c);
        return (c >= RST_LAST) ? RST_LAST : c + RST_W'(1);
    endfunction

    assign accept               = data_if.data_vld_in && !buf_full;
    assign data_if.data_rdy_out = !buf_full;
    assign busy_out             = (state != IDLE);
    assign cnt_inc              = cnt + 8'd1;
    // Timing is sampled for the bit that starts on this edge: a new byte's MSB or the next shifted bit.
    assign sel_bit              = load ? buf_data[7] : shift_q[6];

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_nxt     = bit_idx;
        rst_cnt_nxt = rst_cnt;
        line_nxt    = 1'b0;
        done_nxt    = 1'b0;
        load        = 1'b0;
        advance     = 1'b0;
        case (state)
            IDLE: begin
                if (buf_full) begin
                    load      = 1'b1;
                    state_nxt = SEND;
                    cnt_nxt   = 8'd0;
                    bit_nxt   = 3'd7;
                    line_nxt  = 1'b1;
                end
            end
            SEND: begin
                if (cnt == s_q) begin
                    if (bit_idx == 3'd0) begin
                        if (cur_last) begin
                            state_nxt   = RST;
                            rst_cnt_nxt = '0;
                        end else if (buf_full) begin
                            load     = 1'b1;
                            cnt_nxt  = 8'd0;
                            bit_nxt  = 3'd7;
                            line_nxt = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        advance  = 1'b1;
                        bit_nxt  = bit_idx - 3'd1;
                        cnt_nxt  = 8'd0;
                        line_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt  = cnt_inc;
                    line_nxt = (cnt_inc <= h_q);
                end
            end
            RST: begin
                if (rst_cnt == RST_LAST) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    rst_cnt_nxt = rst_inc(rst_cnt);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= IDLE;
            buf_full     <= 1'b0;
            cnt          <= 8'd0;
            bit_idx      <= 3'd0;
            rst_cnt      <= '0;
            bit_code_out <= 1'b0;
            done_out     <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            bit_idx      <= bit_nxt;
            rst_cnt      <= rst_cnt_nxt;
            bit_code_out <= line_nxt;
            done_out     <= done_nxt;
            if (load)
                buf_full <= 1'b0;
            else if (accept)
                buf_full <= 1'b1;
        end
    end

    // Datapath registers carry no reset; they are always loaded before being used.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            buf_data <= data_if.data_in;
            buf_last <= data_if.data_last_in;
        end
        if (load) begin
            shift_q  <= buf_data;
            cur_last <= buf_last;
        end else if (advance) begin
            shift_q  <= {shift_q[6:0], 1'b0};
        end
        if (load || advance) begin
            h_q <= sel_bit ? t1h_cnt_in : t0h_cnt_in;
            s_q <= sel_bit ? t1s_cnt_in : t0s_cnt_in;
        end
    end
endmodule

// File: tb/tb_layer_code.sv
// Scoreboard bench for layer_code: expected line/busy/done cycles are queued at stimulus time
// and a negedge monitor pops one entry per cycle while a frame is on the line.
module tb_layer_code;
    localparam int RST_CNT = 10;
    localparam int BOUND   = 3000;

    typedef struct packed {
        logic line;
        logic busy;
        logic done;
        logic fin;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] t0h, t0s, t1h, t1s;
    logic       bit_code, busy, done;

    layer_code_if intf ();

    layer_code #(.RST_CNT(RST_CNT), .RST_W(8)) dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .t0h_cnt_in  (t0h),
        .t0s_cnt_in  (t0s),
        .t1h_cnt_in  (t1h),
        .t1s_cnt_in  (t1s),
        .data_if     (intf),
        .bit_code_out(bit_code),
        .busy_out    (busy),
        .done_out    (done)
    );

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic active      = 1'b0;
    logic flush       = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        exp_t e;
        if (flush) begin
            active = 1'b0;
            flush  = 1'b0;
        end else begin
            if (!active && busy) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_busy: busy=%0b with nothing expected at %0t", busy, $time);
                end else begin
                    active = 1'b1;
                end
            end
            if (active) begin
                e = q.pop_front();
                vectors++;
                if (bit_code !== e.line || busy !== e.busy || done !== e.done) begin
                    miscompares++;
                    $display("FAIL line_cycle: got line/busy/done=%0b%0b%0b want %0b%0b%0b at %0t",
                             bit_code, busy, done, e.line, e.busy, e.done, $time);
                end
                if (e.fin) active = 1'b0;
            end else begin
                vectors++;
                if (bit_code !== 1'b0 || done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL idle_line: got line=%0b done=%0b want 0 0 at %0t", bit_code, done, $time);
                end
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_bit(input int nh, input int nl);
        for (int i = 0; i < nh; i++) q.push_back('{1'b1, 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < nl; i++) q.push_back('{1'b0, 1'b1, 1'b0, 1'b0});
    endtask

    task automatic push_byte(input logic [7:0] d, input int h1, input int l1, input int h0, input int l0);
        for (int b = 7; b >= 0; b--) begin
            if (d[b]) push_bit(h1, l1);
            else      push_bit(h0, l0);
        end
    endtask

    task automatic push_end(input logic last);
        if (last) begin
            for (int i = 0; i < RST_CNT; i++) q.push_back('{1'b0, 1'b1, 1'b0, 1'b0});
            q.push_back('{1'b0, 1'b0, 1'b1, 1'b1});
        end else begin
            q.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
        end
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        intf.data_vld_in  = 1'b1;
        intf.data_in      = d;
        intf.data_last_in = last;
        for (int i = 0; i < BOUND; i++) begin
            if (intf.data_rdy_out) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: rdy=%0b want 1 for byte %02h", intf.data_rdy_out, d);
        end
        @(posedge clk);
        #1;
        intf.data_vld_in = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !active) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: %0d expected cycles left, want 0", name, q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        logic seen;
        rst_n             = 1'b1;
        intf.data_vld_in  = 1'b0;
        intf.data_in      = 8'h00;
        intf.data_last_in = 1'b0;
        t0h = 8'd1; t0s = 8'd3; t1h = 8'd2; t1s = 8'd3;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdy",  intf.data_rdy_out, 1'b1);
        check("rst_line", bit_code, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 0xA5 frame, with the next frame's byte accepted before the latch code ends
        push_byte(8'hA5, 3, 1, 2, 2);
        push_end(1'b1);
        push_byte(8'h3C, 3, 1, 2, 2);
        push_end(1'b1);
        send(8'hA5, 1'b1);
        send(8'h3C, 1'b1);
        wait_idle("frame_a5");
        check("after_a5_busy", busy, 1'b0);

        // Back-to-back bytes in one frame: no gap between them
        push_byte(8'hFF, 3, 1, 2, 2);
        push_byte(8'h00, 3, 1, 2, 2);
        push_end(1'b1);
        send(8'hFF, 1'b0);
        send(8'h00, 1'b1);
        wait_idle("b2b");

        // Underrun: last=0 and nothing follows
        push_byte(8'h80, 3, 1, 2, 2);
        push_end(1'b0);
        send(8'h80, 1'b0);
        wait_idle("underrun");
        repeat (5) @(negedge clk);
        check("underrun_busy", busy, 1'b0);
        check("underrun_rdy",  intf.data_rdy_out, 1'b1);

        // t1h changes during the high phase of the first '1' bit
        push_bit(3, 1);
        push_bit(1, 3);
        for (int i = 0; i < 6; i++) push_bit(2, 2);
        push_end(1'b1);
        send(8'hC0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (bit_code) begin
                seen = 1'b1;
                break;
            end
        end
        check("midbit_seen_high", seen, 1'b1);
        t1h = 8'd0;
        wait_idle("midbit");
        t1h = 8'd2;

        // s < h: every '1' bit is all-high
        t1h = 8'd5; t1s = 8'd2;
        push_byte(8'hFF, 3, 0, 2, 2);
        push_end(1'b1);
        send(8'hFF, 1'b1);
        wait_idle("allhigh");
        t1h = 8'd2; t1s = 8'd3;

        // Reset mid-byte with a second byte buffered
        push_byte(8'h80, 3, 1, 2, 2);
        push_end(1'b0);
        send(8'h80, 1'b0);
        send(8'h55, 1'b1);
        #1;
        check("pre_rst_line", bit_code, 1'b1);
        rst_n = 1'b0;
        q.delete();
        flush = 1'b1;
        #1;
        check("midrst_line", bit_code, 1'b0);
        check("midrst_rdy",  intf.data_rdy_out, 1'b1);
        check("midrst_busy", busy, 1'b0);
        @(negedge clk);
        intf.data_vld_in  = 1'b1;
        intf.data_in      = 8'hFF;
        intf.data_last_in = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_ignores_vld", intf.data_rdy_out, 1'b1);
        end
        intf.data_vld_in = 1'b0;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_rdy",  intf.data_rdy_out, 1'b1);

        push_byte(8'h00, 3, 1, 2, 2);
        push_end(1'b1);
        send(8'h00, 1'b1);
        wait_idle("post_rst");

        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_empty: %0d entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
